// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-stage control and PC bus between the sequencer and its environment.
//   master: drives start/stall/halt_req/jump_en/branch_en/cond_flag/call_en/ret_en/jmp_sel/target
//   slave : drives lut_addr/prog_ctr/running/done/jump_cnt/stack_err
interface pc_sequencer_if #(parameter int D = 12);
    logic         start, stall, halt_req, jump_en, branch_en, cond_flag, call_en, ret_en;
    logic [5:0]   jmp_sel, lut_addr;
    logic [D-1:0] target, prog_ctr;
    logic         running, done, stack_err;
    logic [15:0]  jump_cnt;
    modport master (
        output start, stall, halt_req, jump_en, branch_en, cond_flag, call_en, ret_en, jmp_sel, target,
        input  lut_addr, prog_ctr, running, done, jump_cnt, stack_err
    );
    modport slave (
        input  start, stall, halt_req, jump_en, branch_en, cond_flag, call_en, ret_en, jmp_sel, target,
        output lut_addr, prog_ctr, running, done, jump_cnt, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with run/halt control, relative jumps/branches,
// saturating taken-jump counter and optional 4-deep call/return stack (macro PC_RETURN_STACK_EN).
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : pc_sequencer_if slave modport (control inputs, jump-table address/offset, PC and status)
module pc_sequencer #(
    parameter int           D          = 12,
    parameter logic [D-1:0] START_ADDR = '0
) (
    input  logic Clk,
    input  logic Reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    localparam logic [D-1:0] ONE = 1;
    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [15:0]  cnt_q, cnt_d, cnt_inc;
    logic         running_q, running_d, done_q, done_d, take;
`ifdef PC_RETURN_STACK_EN
    logic [D-1:0] stk_q [4];
    logic [D-1:0] stk_d [4];
    logic [2:0]   sp_q, sp_d, sp_m1;
    logic         err_q, err_d;
    assign sp_m1 = sp_q - 3'd1;
    assign take  = bus.jump_en | (bus.branch_en & bus.cond_flag);
    assign bus.stack_err = err_q;
`else
    // Without a stack a call is just another relative jump.
    assign take  = bus.jump_en | bus.call_en | (bus.branch_en & bus.cond_flag);
    assign bus.stack_err = 1'b0;
`endif
    assign cnt_inc      = cnt_q + {15'd0, cnt_q != 16'hFFFF};
    assign bus.lut_addr = bus.jmp_sel;
    assign bus.prog_ctr = pc_q;
    assign bus.jump_cnt = cnt_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef PC_RETURN_STACK_EN
        stk_d   = stk_q;
        sp_d    = sp_q;
        err_d   = err_q;
`endif
        if (state_q != RUN) begin
            if (bus.start) begin
                state_d = RUN;
                pc_d    = START_ADDR;
                cnt_d   = '0;
`ifdef PC_RETURN_STACK_EN
                sp_d    = '0;
                err_d   = 1'b0;
`endif
            end
        end else if (!bus.stall) begin
            if (bus.halt_req)
                state_d = HALT;
`ifdef PC_RETURN_STACK_EN
            else if (bus.ret_en) begin
                // Underflow advances like a normal instruction and is not a taken jump.
                if (sp_q == 3'd0) begin
                    pc_d  = pc_q + ONE;
                    err_d = 1'b1;
                end else begin
                    pc_d  = stk_q[sp_m1[1:0]];
                    sp_d  = sp_m1;
                    cnt_d = cnt_inc;
                end
            end else if (bus.call_en) begin
                // Overflow drops the return address but still jumps.
                if (sp_q == 3'd4)
                    err_d = 1'b1;
                else begin
                    stk_d[sp_q[1:0]] = pc_q + ONE;
                    sp_d = sp_q + 3'd1;
                end
                pc_d  = pc_q + bus.target;
                cnt_d = cnt_inc;
            end
`endif
            else if (take) begin
                pc_d  = pc_q + bus.target;
                cnt_d = cnt_inc;
            end else
                pc_d = pc_q + ONE;
        end
        running_d = state_d == RUN;
        done_d    = state_d == HALT;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef PC_RETURN_STACK_EN
            stk_q     <= '{default: '0};
            sp_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef PC_RETURN_STACK_EN
            stk_q     <= stk_d;
            sp_q      <= sp_d;
            err_q     <= err_d;
`endif
        end
    end
endmodule
